// File: rtl/t_block_xfer.sv
// rtl/t_block_xfer.sv - T register block-transfer sequencer (036 memory->T, 037 T->memory)
// Loads overlap requests with returns; stores run one word per read/capture/write round.
module t_block_xfer #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 6,
  parameter int AWIDTH   = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_dir,
  input  logic [LOGDEPTH-1:0] i_jk,
  input  logic [6:0]          i_count,
  input  logic [AWIDTH-1:0]   i_base,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [AWIDTH-1:0]   o_mem_addr,
  output logic [WIDTH-1:0]    o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic                i_mem_rd_valid,
  input  logic [WIDTH-1:0]    i_mem_rd_data,
  output logic [LOGDEPTH-1:0] o_t_rd_addr,
  input  logic [WIDTH-1:0]    i_t_rd_data,
  output logic                o_t_wr_en,
  output logic [LOGDEPTH-1:0] o_t_wr_addr,
  output logic [WIDTH-1:0]    o_t_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_LD_DRAIN,
    S_ST_RD,
    S_ST_CAP,
    S_ST_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LOGDEPTH-1:0] jk_q, jk_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic [6:0]          count_q, count_d;
  logic [6:0]          issued_q, issued_d;
  logic [6:0]          returned_q, returned_d;
  logic                t_wr_en_q, t_wr_en_d;
  logic [LOGDEPTH-1:0] t_wr_addr_q, t_wr_addr_d;
  logic [WIDTH-1:0]    t_wr_data_q, t_wr_data_d;
  logic [LOGDEPTH-1:0] t_rd_addr_q, t_rd_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  logic [6:0] sat_count;
  logic       ld_active;

  assign sat_count = (i_count > 7'd64) ? 7'd64 : i_count;
  assign ld_active = (state_q == S_LD) || (state_q == S_LD_DRAIN);

  always_comb begin
    state_d     = state_q;
    jk_d        = jk_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    t_wr_en_d   = 1'b0;
    t_wr_addr_d = t_wr_addr_q;
    t_wr_data_d = t_wr_data_q;
    t_rd_addr_d = t_rd_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Returned load data is staged one cycle, then written to T in return order.
    if (ld_active && i_mem_rd_valid && (returned_q != count_q)) begin
      t_wr_en_d   = 1'b1;
      t_wr_addr_d = jk_q + LOGDEPTH'(returned_q);
      t_wr_data_d = i_mem_rd_data;
      returned_d  = returned_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          jk_d       = i_jk;
          base_d     = i_base;
          count_d    = sat_count;
          issued_d   = 7'd0;
          returned_d = 7'd0;
          if (sat_count == 7'd0) begin
            state_d = S_DONE;
          end else if (!i_dir) begin
            state_d = S_LD;
          end else begin
            state_d     = S_ST_RD;
            t_rd_addr_d = i_jk;
          end
        end
      end
      S_LD: begin
        if (i_mem_ack) begin
          issued_d = issued_q + 7'd1;
          if (issued_d == count_q) state_d = S_LD_DRAIN;
        end
      end
      S_LD_DRAIN: begin
        // The final capture's T write is on the port this cycle.
        if (returned_q == count_q) state_d = S_DONE;
      end
      S_ST_RD: state_d = S_ST_CAP;
      S_ST_CAP: begin
        mem_wdata_d = i_t_rd_data;
        state_d     = S_ST_WR;
      end
      S_ST_WR: begin
        if (i_mem_ack) begin
          issued_d = issued_q + 7'd1;
          if (issued_d == count_q) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ST_RD;
            t_rd_addr_d = jk_q + LOGDEPTH'(issued_d);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      jk_q        <= '0;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      t_wr_en_q   <= 1'b0;
      t_wr_addr_q <= '0;
      t_wr_data_q <= '0;
      t_rd_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      jk_q        <= jk_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      t_wr_en_q   <= t_wr_en_d;
      t_wr_addr_q <= t_wr_addr_d;
      t_wr_data_q <= t_wr_data_d;
      t_rd_addr_q <= t_rd_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_mem_req   = (state_q == S_LD) || (state_q == S_ST_WR);
  assign o_mem_we    = (state_q == S_ST_WR);
  assign o_mem_addr  = o_mem_req ? (base_q + AWIDTH'(issued_q)) : '0;
  assign o_mem_wdata = mem_wdata_q;
  assign o_t_rd_addr = t_rd_addr_q;
  assign o_t_wr_en   = t_wr_en_q;
  assign o_t_wr_addr = t_wr_addr_q;
  assign o_t_wr_data = t_wr_data_q;

endmodule

// File: tb/tb_t_block_xfer.sv
// tb/tb_t_block_xfer.sv - randomized bench for t_block_xfer against a list-level transfer model
module tb_t_block_xfer;
  localparam int WIDTH    = 64;
  localparam int LOGDEPTH = 6;
  localparam int AWIDTH   = 22;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                i_start = 1'b0;
  logic                i_dir = 1'b0;
  logic [LOGDEPTH-1:0] i_jk = '0;
  logic [6:0]          i_count = '0;
  logic [AWIDTH-1:0]   i_base = '0;
  logic                o_busy, o_done, o_mem_req, o_mem_we;
  logic [AWIDTH-1:0]   o_mem_addr;
  logic [WIDTH-1:0]    o_mem_wdata;
  logic                i_mem_ack = 1'b0;
  logic                i_mem_rd_valid = 1'b0;
  logic [WIDTH-1:0]    i_mem_rd_data = '0;
  logic [LOGDEPTH-1:0] o_t_rd_addr;
  logic [WIDTH-1:0]    i_t_rd_data = '0;
  logic                o_t_wr_en;
  logic [LOGDEPTH-1:0] o_t_wr_addr;
  logic [WIDTH-1:0]    o_t_wr_data;

  always #5 clk = ~clk;

  t_block_xfer #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_dir(i_dir), .i_jk(i_jk),
    .i_count(i_count), .i_base(i_base), .o_busy(o_busy), .o_done(o_done),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rd_valid(i_mem_rd_valid),
    .i_mem_rd_data(i_mem_rd_data), .o_t_rd_addr(o_t_rd_addr), .i_t_rd_data(i_t_rd_data),
    .o_t_wr_en(o_t_wr_en), .o_t_wr_addr(o_t_wr_addr), .o_t_wr_data(o_t_wr_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // T register file and memory-side models
  logic [WIDTH-1:0]    tfile [64];
  logic [LOGDEPTH-1:0] rd_addr_prev = '0;
  int                  cyc = 0;
  int                  ret_due [$];
  logic [WIDTH-1:0]    ret_data [$];
  int                  ack_mode = 0;
  int                  lat_fixed = 2;
  bit                  directed_data = 1'b0;
  logic [31:0]         salt = 32'h0;
  int                  n_acc = 0;
  int                  wait_cnt = 0;
  int                  n_ret = 0;

  // Observations
  logic [AWIDTH-1:0]   obs_req_addr [$];
  logic                obs_req_we [$];
  logic [WIDTH-1:0]    obs_req_wdata [$];
  logic [LOGDEPTH-1:0] obs_tw_addr [$];
  logic [WIDTH-1:0]    obs_tw_data [$];
  int n_done, done_cyc, busy_cnt, first_req_cyc, last_req_cyc, last_tw_cyc;
  bit                  hold_pending = 1'b0;
  logic [AWIDTH-1:0]   hold_addr;
  logic                hold_we;
  logic [WIDTH-1:0]    hold_wdata;

  function automatic logic [WIDTH-1:0] load_data(input logic [AWIDTH-1:0] a, input int idx);
    if (directed_data) return 64'hA0 + 64'(idx);
    return {salt, 10'h0, a};
  endfunction

  task automatic clear_obs();
    obs_req_addr.delete(); obs_req_we.delete(); obs_req_wdata.delete();
    obs_tw_addr.delete(); obs_tw_data.delete();
    ret_due.delete(); ret_data.delete();
    n_done = 0; done_cyc = -1; busy_cnt = 0; first_req_cyc = -1;
    last_req_cyc = -1; last_tw_cyc = -1; n_acc = 0; wait_cnt = 0; n_ret = 0;
    hold_pending = 1'b0;
  endtask

  // One clock: observe outputs at the falling edge, then drive the responses for this cycle.
  task automatic cycle();
    int lat;
    @(negedge clk);
    cyc++;
    if (o_t_wr_en) begin
      obs_tw_addr.push_back(o_t_wr_addr);
      obs_tw_data.push_back(o_t_wr_data);
      tfile[o_t_wr_addr] = o_t_wr_data;
      last_tw_cyc = cyc;
    end
    if (o_done) begin n_done++; done_cyc = cyc; end
    if (o_busy) busy_cnt++;
    if (hold_pending) begin
      check("hold_req", o_mem_req, 1);
      check("hold_addr", o_mem_addr, hold_addr);
      check("hold_we", o_mem_we, hold_we);
      check("hold_wdata", o_mem_wdata, hold_wdata);
    end
    i_t_rd_data  = tfile[rd_addr_prev];
    rd_addr_prev = o_t_rd_addr;
    i_mem_rd_valid = 1'b0;
    i_mem_rd_data  = '0;
    if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
      void'(ret_due.pop_front());
      i_mem_rd_valid = 1'b1;
      i_mem_rd_data  = ret_data.pop_front();
      n_ret++;
    end
    case (ack_mode)
      0:       i_mem_ack = 1'b1;
      1:       i_mem_ack = ($urandom_range(0, 1) == 1);
      default: i_mem_ack = !(n_acc == 1 && wait_cnt < 2);
    endcase
    if (o_mem_req) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (i_mem_ack) begin
        obs_req_addr.push_back(o_mem_addr);
        obs_req_we.push_back(o_mem_we);
        obs_req_wdata.push_back(o_mem_wdata);
        last_req_cyc = cyc;
        if (!o_mem_we) begin
          lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
          ret_due.push_back(cyc + lat);
          ret_data.push_back(load_data(o_mem_addr, n_acc));
        end
        n_acc++;
        wait_cnt = 0;
        hold_pending = 1'b0;
      end else begin
        wait_cnt++;
        hold_pending = 1'b1;
        hold_addr = o_mem_addr; hold_we = o_mem_we; hold_wdata = o_mem_wdata;
      end
    end else begin
      hold_pending = 1'b0;
    end
  endtask

  task automatic run_xfer(input string nm, input bit dir, input logic [5:0] jk,
                          input logic [21:0] base, input logic [6:0] cnt,
                          input int amode, input int lat, input bit poke);
    int n, start_cyc, budget, m;
    logic [WIDTH-1:0] tsnap [64];
    n = (cnt > 7'd64) ? 64 : int'(cnt);
    clear_obs();
    tsnap = tfile;
    ack_mode = amode; lat_fixed = lat;
    i_dir = dir; i_jk = jk; i_base = base; i_count = cnt; i_start = 1'b1;
    start_cyc = cyc;
    budget = 0;
    do begin
      cycle();
      budget++;
      i_start = poke && (cyc == start_cyc + 3);
      if (i_start) begin
        i_dir = ~dir; i_jk = jk + 6'd1; i_base = base + 22'd5; i_count = 7'd9;
      end
    end while (n_done == 0 && budget < 3000);
    i_start = 1'b0;
    check({nm, ".timeout"}, budget < 3000, 1);
    repeat (3) cycle();
    check({nm, ".ndone"}, n_done, 1);
    check({nm, ".busy_end"}, o_busy, 0);
    check({nm, ".busy_cnt"}, busy_cnt, done_cyc - start_cyc);
    check({nm, ".nreq"}, obs_req_addr.size(), n);
    m = (obs_req_addr.size() < n) ? obs_req_addr.size() : n;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.addr%0d", nm, i), obs_req_addr[i], AWIDTH'(base + 22'(i)));
      check($sformatf("%s.we%0d", nm, i), obs_req_we[i], dir);
      if (dir)
        check($sformatf("%s.wdata%0d", nm, i), obs_req_wdata[i], tsnap[6'(jk + 6'(i))]);
    end
    check({nm, ".ntw"}, obs_tw_addr.size(), dir ? 0 : n);
    if (!dir) begin
      m = (obs_tw_addr.size() < n) ? obs_tw_addr.size() : n;
      for (int i = 0; i < m; i++) begin
        check($sformatf("%s.twa%0d", nm, i), obs_tw_addr[i], 6'(jk + 6'(i)));
        check($sformatf("%s.twd%0d", nm, i), obs_tw_data[i], load_data(AWIDTH'(base + 22'(i)), i));
      end
    end
    if (n == 0) begin
      check({nm, ".done_at"}, done_cyc, start_cyc + 1);
      check({nm, ".no_req"}, first_req_cyc, -1);
    end else if (!dir) begin
      check({nm, ".done_after_tw"}, done_cyc, last_tw_cyc + 1);
      if (amode == 0) begin
        check({nm, ".first_req"}, first_req_cyc, start_cyc + 1);
        check({nm, ".last_req"}, last_req_cyc, start_cyc + n);
      end
    end else begin
      check({nm, ".done_after_ack"}, done_cyc, last_req_cyc + 1);
      if (amode == 0) check({nm, ".st_rate"}, done_cyc, start_cyc + 3 * n + 1);
    end
  endtask

  initial begin
    int tw_at_reset, budget;
    for (int i = 0; i < 64; i++) tfile[i] = {$urandom, $urandom};
    clear_obs();
    repeat (2) cycle();
    check("rst.busy", o_busy, 0);
    check("rst.done", o_done, 0);
    check("rst.req", o_mem_req, 0);
    check("rst.twen", o_t_wr_en, 0);
    check("rst.addr", o_mem_addr, 0);
    rst = 1'b1;
    repeat (2) cycle();

    directed_data = 1'b1;
    run_xfer("ld_dir", 1'b0, 6'd5, 22'h100, 7'd4, 0, 2, 1'b0);
    directed_data = 1'b0;
    salt = $urandom;
    tfile[62] = 64'h11; tfile[63] = 64'h22; tfile[0] = 64'h33;
    run_xfer("st_dir", 1'b1, 6'd62, 22'h200, 7'd3, 2, 2, 1'b0);
    run_xfer("ld_zero", 1'b0, 6'd7, 22'h55, 7'd0, 0, 2, 1'b0);
    run_xfer("st_zero", 1'b1, 6'd7, 22'h55, 7'd0, 0, 2, 1'b0);
    run_xfer("ld_sat", 1'b0, 6'd10, 22'h1234, 7'd100, 0, 0, 1'b0);
    run_xfer("ld_wrap", 1'b0, 6'd20, 22'h3FFFFE, 7'd4, 0, 3, 1'b0);
    run_xfer("st_sat", 1'b1, 6'd33, 22'h3FFFE0, 7'd127, 0, 2, 1'b0);
    run_xfer("st_poke", 1'b1, 6'd1, 22'h300, 7'd5, 1, 2, 1'b1);
    run_xfer("ld_poke", 1'b0, 6'd60, 22'h400, 7'd6, 1, 0, 1'b1);

    // Reset in the middle of a load
    clear_obs();
    ack_mode = 0; lat_fixed = 2;
    i_dir = 1'b0; i_jk = 6'd3; i_base = 22'h40; i_count = 7'd4; i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    budget = 0;
    while (n_ret < 2 && budget < 50) begin cycle(); budget++; end
    check("mid.reached", n_ret, 2);
    tw_at_reset = obs_tw_addr.size();
    rst = 1'b0;
    #1;
    check("mid.busy", o_busy, 0);
    check("mid.done", o_done, 0);
    check("mid.req", o_mem_req, 0);
    check("mid.we", o_mem_we, 0);
    check("mid.addr", o_mem_addr, 0);
    check("mid.wdata", o_mem_wdata, 0);
    check("mid.rdaddr", o_t_rd_addr, 0);
    check("mid.twen", o_t_wr_en, 0);
    check("mid.twaddr", o_t_wr_addr, 0);
    check("mid.twdata", o_t_wr_data, 0);
    hold_pending = 1'b0;
    cycle();
    rst = 1'b1;
    ret_due.push_back(cyc + 1); ret_data.push_back(64'hDEAD);
    ret_due.push_back(cyc + 2); ret_data.push_back(64'hBEEF);
    repeat (6) cycle();
    check("mid.no_tw", obs_tw_addr.size(), tw_at_reset);
    check("mid.idle", o_busy, 0);
    run_xfer("post_rst", 1'b0, 6'd3, 22'h40, 7'd4, 0, 2, 1'b0);

    for (int k = 0; k < 14; k++) begin
      logic [6:0] c;
      logic [21:0] b;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) c = 7'd0;
      else if (r == 1) c = 7'($urandom_range(64, 127));
      else c = 7'($urandom_range(1, 64));
      b = ($urandom_range(0, 3) == 0) ? 22'h3FFFC0 + 22'($urandom_range(0, 63)) : 22'($urandom);
      salt = $urandom;
      run_xfer($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 6'($urandom), b, c,
               int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
